// File: rtl/ofdm_symbol_serializer.sv
// Parallel-to-serial unloader for one 8-point complex OFDM symbol.
// Captures all 8 samples at once and streams them out index 0 first, descaled, rounded and saturated.
module ofdm_symbol_serializer #(
  parameter int W         = 24,
  parameter int OUT_W     = 12,
  parameter int FRAC_BITS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x0_real,
  input  logic [W-1:0]     x0_imag,
  input  logic [W-1:0]     x1_real,
  input  logic [W-1:0]     x1_imag,
  input  logic [W-1:0]     x2_real,
  input  logic [W-1:0]     x2_imag,
  input  logic [W-1:0]     x3_real,
  input  logic [W-1:0]     x3_imag,
  input  logic [W-1:0]     x4_real,
  input  logic [W-1:0]     x4_imag,
  input  logic [W-1:0]     x5_real,
  input  logic [W-1:0]     x5_imag,
  input  logic [W-1:0]     x6_real,
  input  logic [W-1:0]     x6_imag,
  input  logic [W-1:0]     x7_real,
  input  logic [W-1:0]     x7_imag,
  output logic [OUT_W-1:0] out_x,
  output logic [OUT_W-1:0] out_y,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic signed [W:0] RND  = (W+1)'(2**(FRAC_BITS-1));
  localparam logic signed [W:0] MAXV = (W+1)'(2**(OUT_W-1)-1);
  localparam logic signed [W:0] MINV = ~MAXV;

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q;
  logic [2:0]     idx_q;
  logic [W-1:0]   re_q [8];
  logic [W-1:0]   im_q [8];
  logic [W-1:0]   re_in [8];
  logic [W-1:0]   im_in [8];
  logic           load;

  assign re_in[0] = x0_real;  assign im_in[0] = x0_imag;
  assign re_in[1] = x1_real;  assign im_in[1] = x1_imag;
  assign re_in[2] = x2_real;  assign im_in[2] = x2_imag;
  assign re_in[3] = x3_real;  assign im_in[3] = x3_imag;
  assign re_in[4] = x4_real;  assign im_in[4] = x4_imag;
  assign re_in[5] = x5_real;  assign im_in[5] = x5_imag;
  assign re_in[6] = x6_real;  assign im_in[6] = x6_imag;
  assign re_in[7] = x7_real;  assign im_in[7] = x7_imag;

  // Round half-up by biasing before the arithmetic shift, then clamp to OUT_W.
  function automatic logic [OUT_W-1:0] descale(input logic [W-1:0] v);
    logic        [W:0] t;
    logic signed [W:0] s;
    t = {v[W-1], v} + RND;
    s = $signed(t) >>> FRAC_BITS;
    if (s > MAXV)      return MAXV[OUT_W-1:0];
    else if (s < MINV) return MINV[OUT_W-1:0];
    else               return s[OUT_W-1:0];
  endfunction

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_last  = out_valid & (idx_q == 3'd7);
  assign out_x     = descale(re_q[idx_q]);
  assign out_y     = descale(im_q[idx_q]);

  // Reloading on the last accepted beat keeps back-to-back symbols bubble-free.
  assign in_ready = ~reset & ((state_q == IDLE) | (out_valid & out_ready & out_last));
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else begin
      if (load) begin
        for (int k = 0; k < 8; k++) begin
          re_q[k] <= re_in[k];
          im_q[k] <= im_in[k];
        end
      end
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= SEND;
            idx_q   <= 3'd0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx_q != 3'd7) idx_q <= idx_q + 3'd1;
            else if (load)     idx_q <= 3'd0;
            else               state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_symbol_serializer.sv
// Bench for ofdm_symbol_serializer: directed steps plus random traffic, checked
// against a queue-based model using integer floor-division descaling.
module tb_ofdm_symbol_serializer;

  logic        clk, reset, in_valid, in_ready, out_ready;
  logic [23:0] xr [8];
  logic [23:0] xi [8];
  logic [11:0] out_x, out_y;
  logic [2:0]  out_idx;
  logic        out_last, out_valid, busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  typedef struct {
    logic signed [63:0] x;
    logic signed [63:0] y;
    logic [2:0]         idx;
  } beat_t;
  beat_t q[$];

  ofdm_symbol_serializer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x0_real(xr[0]), .x0_imag(xi[0]), .x1_real(xr[1]), .x1_imag(xi[1]),
    .x2_real(xr[2]), .x2_imag(xi[2]), .x3_real(xr[3]), .x3_imag(xi[3]),
    .x4_real(xr[4]), .x4_imag(xi[4]), .x5_real(xr[5]), .x5_imag(xi[5]),
    .x6_real(xr[6]), .x6_imag(xi[6]), .x7_real(xr[7]), .x7_imag(xi[7]),
    .out_x(out_x), .out_y(out_y), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // value/4096 rounded half-up = floor((v+2048)/4096), clamped to 12-bit signed
  function automatic logic signed [63:0] ref_q(input logic [23:0] v);
    longint t, s;
    t = longint'($signed(v)) + 2048;
    if (t >= 0) s = t / 4096;
    else        s = -((-t + 4095) / 4096);
    if (s > 2047)  s = 2047;
    if (s < -2048) s = -2048;
    return s;
  endfunction

  function automatic logic [23:0] rnd24();
    if ($urandom_range(0, 2) == 0) return 24'($urandom);
    return 24'($urandom_range(0, 65535)) - 24'd32768;
  endfunction

  task automatic rand_sym();
    for (int k = 0; k < 8; k++) begin
      xr[k] = rnd24();
      xi[k] = rnd24();
    end
  endtask

  task automatic send_load();
    in_valid = 1;
    @(posedge clk); #2;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic wait_idx(input logic [2:0] target, input string tag);
    int n = 0;
    while (!(out_valid === 1'b1 && out_idx === target) && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    chk(tag, out_idx, target);
  endtask

  // Cycle model: the queue holds the beats still owed downstream.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_rdy;
      exp_rdy = !reset && (q.size() == 0 || (q.size() == 1 && out_ready));
      chk("mon_in_ready", in_ready, exp_rdy);
      chk("mon_out_valid", out_valid, q.size() != 0);
      chk("mon_busy", busy, q.size() != 0);
      if (q.size() != 0) begin
        chk("mon_out_x", $signed(out_x), q[0].x);
        chk("mon_out_y", $signed(out_y), q[0].y);
        chk("mon_out_idx", out_idx, q[0].idx);
        chk("mon_out_last", out_last, q[0].idx == 3'd7);
      end else begin
        chk("mon_out_last_idle", out_last, 0);
      end
      if (reset) q.delete();
      else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy)
          for (int k = 0; k < 8; k++) q.push_back('{ref_q(xr[k]), ref_q(xi[k]), 3'(k)});
      end
    end
  end

  initial begin
    logic [23:0]        rv [6];
    logic signed [63:0] re [6];
    reset = 1; in_valid = 1; out_ready = 1;
    rand_sym();

    // 1: reset held 3 cycles with in_valid high
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      mon_en = 1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_x", $signed(out_x), 0);
      chk("rst_out_y", $signed(out_y), 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
    end
    reset = 0; in_valid = 0;
    @(posedge clk); #2;
    chk("rst_no_capture", busy, 0);

    // 2: single symbol k*4096 / -k*4096
    for (int k = 0; k < 8; k++) begin
      xr[k] = 24'(k * 4096);
      xi[k] = 24'(-k * 4096);
    end
    send_load();
    for (int k = 0; k < 8; k++) begin
      chk("single_valid", out_valid, 1);
      chk("single_x", $signed(out_x), k);
      chk("single_y", $signed(out_y), -k);
      chk("single_idx", out_idx, k);
      chk("single_last", out_last, k == 7);
      @(posedge clk); #2;
    end
    chk("single_end", out_valid, 0);

    // 3: rounding and saturation corners
    rv = '{24'd2047, 24'd2048, 24'hFFF800, 24'hFFF7FF, 24'h7FFFFF, 24'h800000};
    re = '{0, 1, 0, -1, 2047, -2048};
    rand_sym();
    for (int k = 0; k < 6; k++) xr[k] = rv[k];
    send_load();
    for (int k = 0; k < 6; k++) begin
      chk("round_x", $signed(out_x), re[k]);
      @(posedge clk); #2;
    end
    drain();

    // 4: backpressure at idx 3
    rand_sym();
    send_load();
    wait_idx(3'd3, "bp_reach3");
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      chk("bp_idx_hold", out_idx, 3);
      chk("bp_x_hold", $signed(out_x), ref_q(xr[3]));
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    for (int k = 3; k < 8; k++) begin
      chk("bp_resume_idx", out_idx, k);
      @(posedge clk); #2;
    end
    chk("bp_end", out_valid, 0);

    // 5: back-to-back symbols A then B
    rand_sym();
    send_load();
    for (int i = 0; i < 16; i++) begin
      chk("b2b_valid", out_valid, 1);
      chk("b2b_idx", out_idx, i % 8);
      if (i == 7) begin
        rand_sym();
        in_valid = 1;
        #1 chk("b2b_in_ready", in_ready, 1);
      end
      if (i == 8) in_valid = 0;
      @(posedge clk); #2;
    end
    chk("b2b_end", out_valid, 0);

    // 6: reset mid-burst at idx 5, then a fresh symbol
    rand_sym();
    send_load();
    wait_idx(3'd5, "mid_reach5");
    reset = 1;
    @(posedge clk); #2;
    chk("mid_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    reset = 0;
    rand_sym();
    send_load();
    chk("mid_restart_idx", out_idx, 0);
    chk("mid_restart_x", $signed(out_x), ref_q(xr[0]));
    chk("mid_restart_y", $signed(out_y), ref_q(xi[0]));
    drain();

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_sym();
    end
    in_valid = 0; out_ready = 1;
    drain();

    @(posedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
